dm_wb_dcache: RTL and testbench
===============================

Name: dm_wb_dcache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the WISC_S14 cpu data-memory port and the unified main memory model.
- Hits are returned with zero stall; a miss stalls the cpu while a 3-state FSM writes back a dirty victim and then refills the line.
- Includes saturating hit/miss counters that the cpu bench prints at halt next to the cycle count.

Parameters:
- SETS, 8, number of lines; power of 2, index width IW = log2(SETS).
- LINE_WORDS, 4, 16-bit words per line; power of 2, offset width OW = log2(LINE_WORDS).
- TW, 16-IW-OW (= 11), tag width; derived, never overridden.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  16  cpu word address; split as {tag[TW], index[IW], offset[OW]}.
- re  in  1  cpu read request.
- we  in  1  cpu write request.
- wdata  in  16  cpu write data.
- rdata  out  16  read data; valid when re=1 and stall=0.
- stall  out  1  cpu must hold addr/re/we/wdata stable while this is 1.
- mem_addr  out  16  line-aligned memory address (offset bits = 0).
- mem_re  out  1  line-read request.
- mem_we  out  1  line-write request.
- mem_wdata  out  16*LINE_WORDS  victim line; word 0 in the LSBs.
- mem_rdata  in  16*LINE_WORDS  refill line; word 0 in the LSBs.
- mem_rdy  in  1  one-cycle pulse: the current mem request has completed.
- hit_cnt  out  16  accesses completed as hits; saturates at 16'hFFFF.
- miss_cnt  out  16  misses detected; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All valid and dirty bits clear; state IDLE.
  - stall=0, mem_re=0, mem_we=0, mem_addr=0, rdata=0, hit_cnt=0, miss_cnt=0.
  - Data and tag arrays are not cleared.
  - Reset mid-miss aborts the transfer: mem_re/mem_we are 0 from the next cycle and any in-flight mem_rdy is ignored. Dirty data is lost.
- Request definition: req = re|we. If re and we are both 1, the access is treated as a write and rdata is don't-care.
- Hit: hit = req & valid[index] & (tag_arr[index] == tag).
- State IDLE:
  - Read hit: rdata = word[offset] combinationally in the same cycle; stall=0; hit_cnt+1.
  - Write hit: the word is written at the edge, dirty[index]=1, stall=0, hit_cnt+1.
  - Miss: stall=1 combinationally; miss_cnt+1. Next state is WB if valid & dirty, otherwise ALLOC.
  - No request: nothing changes and stall=0.
- State WB:
  - stall=1, mem_we=1, mem_addr={tag_arr[index], index, OW'b0}, mem_wdata=line[index].
  - Held stable until mem_rdy=1, then go to ALLOC.
- State ALLOC:
  - stall=1, mem_re=1, mem_addr={tag, index, OW'b0}.
  - On mem_rdy=1: line[index]=mem_rdata, tag_arr[index]=tag, valid=1, dirty=0; go to IDLE.
- Retry after refill: in the following IDLE cycle the held request hits, is served, and counts as a hit. Latency on a miss is therefore memory time plus 1 cycle.
- Handshake:
  - mem_re and mem_we are never both 1.
  - mem_rdy seen in IDLE is ignored.
  - Memory latency is unbounded; there is no timeout.
- Counters:
  - Counted only in IDLE; they do not wrap.
  - Counting is not suppressed while stall=1 in IDLE, because a miss is counted once on entry.
- Output timing: stall and rdata are combinational from state, arrays and inputs. The mem_* outputs are decoded from state only.

Decomposition:
- Package dcache_pkg holds:
  - State encoding IDLE=2'd0, WB=2'd1, ALLOC=2'd2.
  - Default SETS and LINE_WORDS, and the TW/IW/OW derivation functions.
  - The line-packing helper (word i at bits [16i+15:16i]).
- One natural sub-module, dcache_arrays: tag, valid, dirty and data storage, with a write-word port, a fill-line port and combinational read.
- The FSM and counters stay in dm_wb_dcache.

Test Plan:
- Cold read miss: rst, then read addr=16'h0010, memory returns line {4'hD,4'hC,4'hB,4'hA} words after 3 cycles. Required: stall=1 for 5 cycles, one mem_re with mem_addr=16'h0010, then rdata=16'h000A with stall=0; miss_cnt=1, hit_cnt=1.
- Write hit: after the previous test, write 16'hBEEF to addr 16'h0011. Required: no stall and no mem traffic; a following read of 16'h0011 returns 16'hBEEF and hit_cnt=3.
- Dirty eviction: read addr 16'h0030 (same index, different tag). Required: mem_we first with mem_addr=16'h0010 and mem_wdata word1=16'hBEEF, then mem_re with mem_addr=16'h0030; returned data is correct; miss_cnt=2.
- Clean eviction: read 16'h0010 again after a clean fill of 16'h0030. Required: mem_re only, mem_we never asserted.
- Reset mid-ALLOC: assert rst while mem_re=1. Required: next cycle mem_re=0, stall=0, counters=0; a read of the same address misses again.
- Saturation: preload hit_cnt near its limit via 65540 hits to one line. Required: hit_cnt=16'hFFFF and stays there; re=we=1 to a hit line performs the write only.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared constants and helpers for the direct-mapped write-back data cache.
package dcache_pkg;

    // Controller states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WB    = 2'd1;
    localparam logic [1:0] ALLOC = 2'd2;

    // Default geometry and fixed word/address widths
    localparam int DEF_SETS       = 8;
    localparam int DEF_LINE_WORDS = 4;
    localparam int WORD_W         = 16;
    localparam int ADDR_W         = 16;

    // Address field widths: addr = {tag, index, offset}
    function automatic int calc_iw(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_ow(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int calc_tw(input int sets, input int line_words);
        return ADDR_W - calc_iw(sets) - calc_ow(line_words);
    endfunction

    // Line packing: word i lives at bits [16i+15:16i] of a line
    function automatic int word_lsb(input int i);
        return WORD_W * i;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dcache_arrays.sv
// Tag/valid/dirty/data storage for the cache. One combinational read port,
// a single-word write port (marks the line dirty) and a whole-line fill port
// (marks the line valid and clean). Only valid/dirty are cleared by reset.
module dcache_arrays
    import dcache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    localparam int IW = calc_iw(SETS),
    localparam int OW = calc_ow(LINE_WORDS),
    localparam int TW = calc_tw(SETS, LINE_WORDS),
    localparam int LW = WORD_W * LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     rd_index,
    output logic [TW-1:0]     rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [LW-1:0]     rd_line,
    input  logic              ww_en,
    input  logic [IW-1:0]     ww_index,
    input  logic [OW-1:0]     ww_offset,
    input  logic [WORD_W-1:0] ww_data,
    input  logic              fill_en,
    input  logic [IW-1:0]     fill_index,
    input  logic [TW-1:0]     fill_tag,
    input  logic [LW-1:0]     fill_line
);

    logic [TW-1:0]   tag_q  [SETS];
    logic [TW-1:0]   tag_d  [SETS];
    logic [LW-1:0]   data_q [SETS];
    logic [LW-1:0]   data_d [SETS];
    logic [SETS-1:0] valid_q, valid_d;
    logic [SETS-1:0] dirty_q, dirty_d;

    // Next-state of the arrays: a fill replaces a whole line, a word write
    // patches one word. The controller never requests both in one cycle.
    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en) begin
            data_d[fill_index]  = fill_line;
            tag_d[fill_index]   = fill_tag;
            valid_d[fill_index] = 1'b1;
            dirty_d[fill_index] = 1'b0;
        end
        if (ww_en) begin
            data_d[ww_index][word_lsb(int'(ww_offset)) +: WORD_W] = ww_data;
            dirty_d[ww_index] = 1'b1;
        end
    end

    // Line status bits; reset invalidates everything and drops dirty data
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data storage; contents survive reset
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/dm_wb_dcache.sv
// Direct-mapped, write-back, write-allocate data cache. Hits complete with no
// stall; a miss stalls the cpu while the controller writes back a dirty victim
// (WB) and refills the line (ALLOC), after which the held request hits.
//
// Memory handshake: in WB/ALLOC the request (mem_we or mem_re, never both) and
// mem_addr/mem_wdata are held constant until a one-cycle mem_rdy pulse marks
// completion; mem_rdy arriving while IDLE has no effect. There is no timeout.
module dm_wb_dcache
    import dcache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          re,
    input  logic                          we,
    input  logic [WORD_W-1:0]             wdata,
    output logic [WORD_W-1:0]             rdata,
    output logic                          stall,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_re,
    output logic                          mem_we,
    output logic [WORD_W*LINE_WORDS-1:0]  mem_wdata,
    input  logic [WORD_W*LINE_WORDS-1:0]  mem_rdata,
    input  logic                          mem_rdy,
    output logic [15:0]                   hit_cnt,
    output logic [15:0]                   miss_cnt
);

    localparam int IW = calc_iw(SETS);
    localparam int OW = calc_ow(LINE_WORDS);
    localparam int TW = calc_tw(SETS, LINE_WORDS);
    localparam int LW = WORD_W * LINE_WORDS;

    logic [1:0]  state_q, state_d;
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    logic [TW-1:0] a_tag;
    logic [IW-1:0] a_index;
    logic [OW-1:0] a_offset;
    logic [TW-1:0] rd_tag;
    logic          rd_valid;
    logic          rd_dirty;
    logic [LW-1:0] rd_line;
    logic          req;
    logic          hit;
    logic          ww_en;
    logic          fill_en;

    assign a_tag    = addr[ADDR_W-1 -: TW];
    assign a_index  = addr[OW +: IW];
    assign a_offset = addr[OW-1:0];

    assign req = re | we;
    assign hit = req & rd_valid & (rd_tag == a_tag);

    dcache_arrays #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_arrays (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (a_index),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_line    (rd_line),
        .ww_en      (ww_en),
        .ww_index   (a_index),
        .ww_offset  (a_offset),
        .ww_data    (wdata),
        .fill_en    (fill_en),
        .fill_index (a_index),
        .fill_tag   (a_tag),
        .fill_line  (mem_rdata)
    );

    // Controller: outputs, array write strobes, counters and next state.
    // A write (including re&we together) takes priority over returning data.
    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        stall      = 1'b0;
        rdata      = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ww_en      = 1'b0;
        fill_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (we) begin
                        ww_en = 1'b1;
                    end else begin
                        rdata = rd_line[word_lsb(int'(a_offset)) +: WORD_W];
                    end
                    hit_cnt_d = sat_inc16(hit_cnt_q);
                end else if (req) begin
                    stall      = 1'b1;
                    miss_cnt_d = sat_inc16(miss_cnt_q);
                    state_d    = (rd_valid & rd_dirty) ? WB : ALLOC;
                end
            end
            WB: begin
                stall     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, a_index, {OW{1'b0}}};
                mem_wdata = rd_line;
                if (mem_rdy) begin
                    state_d = ALLOC;
                end
            end
            ALLOC: begin
                stall    = 1'b1;
                mem_re   = 1'b1;
                mem_addr = {a_tag, a_index, {OW{1'b0}}};
                if (mem_rdy) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Reset aborts any transfer; a late mem_rdy must not install a line
        if (rst) begin
            ww_en   = 1'b0;
            fill_en = 1'b0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_dm_wb_dcache.sv
// Self-checking bench for dm_wb_dcache: directed scenarios followed by random
// accesses, all checked against a line-level cache and memory model.
module tb_dm_wb_dcache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        stall;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_rdy = 1'b0;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    dm_wb_dcache #(.SETS(8), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .re        (re),
        .we        (we),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory contents seen by the responder, and the model's own copy
    logic [15:0] tb_mem  [65536];
    logic [15:0] ref_mem [65536];

    // Responder state and transaction log
    bit          rsp_busy = 1'b0;
    bit          rsp_wr = 1'b0;
    int          rsp_cnt = 0;
    logic [15:0] rsp_addr = '0;
    logic [63:0] rsp_data = '0;
    int          mem_lat = 3;
    int          wb_cnt = 0;
    int          rd_cnt = 0;
    int          both_cnt = 0;
    int          ev_seq = 0;
    int          wb_seq = 0;
    int          rd_seq = 0;
    logic [15:0] last_wb_addr = '0;
    logic [15:0] last_rd_addr = '0;
    logic [63:0] last_wb_data = '0;

    // Memory responder: accepts a request, waits mem_lat cycles, pulses mem_rdy
    always @(negedge clk) begin
        mem_rdy = 1'b0;
        if (mem_re === 1'b1 && mem_we === 1'b1) both_cnt++;
        if (rsp_busy) begin
            if (rsp_cnt == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (rsp_wr) tb_mem[16'(rsp_addr + k)] = rsp_data[16*k +: 16];
                    else mem_rdata[16*k +: 16] = tb_mem[16'(rsp_addr + k)];
                end
                mem_rdy  = 1'b1;
                rsp_busy = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end else if (mem_we === 1'b1) begin
            rsp_busy = 1'b1; rsp_wr = 1'b1; rsp_cnt = mem_lat - 1;
            rsp_addr = mem_addr; rsp_data = mem_wdata;
            wb_cnt++; ev_seq++; wb_seq = ev_seq;
            last_wb_addr = mem_addr; last_wb_data = mem_wdata;
        end else if (mem_re === 1'b1) begin
            rsp_busy = 1'b1; rsp_wr = 1'b0; rsp_cnt = mem_lat - 1;
            rsp_addr = mem_addr;
            rd_cnt++; ev_seq++; rd_seq = ev_seq;
            last_rd_addr = mem_addr;
        end
    end

    // Reference model: cache contents and counters
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [10:0] m_tag   [8];
    logic [15:0] m_line  [8][4];
    int          m_hit = 0;
    int          m_miss = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cpu access, started and finished at posedge+1; predicts and checks it
    task automatic access(input logic [15:0] a, input logic r, input logic w,
                          input logic [15:0] d, output int n_stall, output logic [15:0] got);
        logic [2:0]  idx;
        logic [10:0] tg;
        logic [1:0]  off;
        bit          e_hit;
        bit          e_wb;
        int          e_stall;
        int          wb0;
        int          rd0;
        logic [15:0] e_wb_addr;
        logic [15:0] e_rd_addr;
        logic [15:0] e_rdata;
        logic [63:0] e_wb_data;
        idx = a[4:2];
        tg  = a[15:5];
        off = a[1:0];
        e_hit = m_valid[idx] && (m_tag[idx] == tg);
        e_wb  = !e_hit && m_valid[idx] && m_dirty[idx];
        e_wb_addr = {m_tag[idx], idx, 2'b00};
        e_rd_addr = {tg, idx, 2'b00};
        e_wb_data = {m_line[idx][3], m_line[idx][2], m_line[idx][1], m_line[idx][0]};
        if (e_wb) begin
            for (int k = 0; k < 4; k++) ref_mem[16'(e_wb_addr + k)] = m_line[idx][k];
        end
        if (!e_hit) begin
            for (int k = 0; k < 4; k++) m_line[idx][k] = ref_mem[16'(e_rd_addr + k)];
            m_tag[idx]   = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            if (m_miss < 65535) m_miss++;
        end
        e_stall = e_hit ? 0 : 1 + (e_wb ? mem_lat + 1 : 0) + mem_lat + 1;
        e_rdata = m_line[idx][off];
        if (w) begin
            m_line[idx][off] = d;
            m_dirty[idx] = 1'b1;
        end
        if (m_hit < 65535) m_hit++;
        wb0 = wb_cnt;
        rd0 = rd_cnt;
        addr = a; re = r; we = w; wdata = d;
        #1;
        n_stall = 0;
        while (stall === 1'b1 && n_stall < 2000) begin
            n_stall++;
            @(posedge clk);
            #2;
        end
        got = rdata;
        @(posedge clk);
        #1;
        re = 1'b0;
        we = 1'b0;
        chk("stall_cycles", 64'(n_stall), 64'(e_stall));
        if (r && !w) chk("rdata", got, e_rdata);
        chk("wb_count", 64'(wb_cnt - wb0), 64'(e_wb));
        chk("refill_count", 64'(rd_cnt - rd0), 64'(!e_hit));
        if (e_wb) begin
            chk("wb_addr", last_wb_addr, e_wb_addr);
            chk("wb_data", last_wb_data, e_wb_data);
        end
        if (!e_hit) chk("refill_addr", last_rd_addr, e_rd_addr);
        chk("hit_cnt", hit_cnt, 64'(m_hit));
        chk("miss_cnt", miss_cnt, 64'(m_miss));
    endtask

    int          ns;
    logic [15:0] g;
    int          wb_mark;
    int          rd_mark;
    int          wait_n;

    initial begin
        // Memory image: pseudo-random words, plus the A/B/C/D line at 0x0010
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i]  = 16'((i * 37) ^ 16'hC3A5);
            ref_mem[i] = 16'((i * 37) ^ 16'hC3A5);
        end
        for (int k = 0; k < 4; k++) begin
            tb_mem[16 + k]  = 16'(10 + k);
            ref_mem[16 + k] = 16'(10 + k);
        end
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
            m_tag[s]   = '0;
            for (int k = 0; k < 4; k++) m_line[s][k] = '0;
        end

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_hit_cnt", hit_cnt, 16'h0000);
        chk("rst_miss_cnt", miss_cnt, 16'h0000);
        rst = 1'b0;

        // Cold read miss
        mem_lat = 3;
        access(16'h0010, 1'b1, 1'b0, 16'h0000, ns, g);
        chk("cold_stall", 64'(ns), 64'd5);
        chk("cold_rdata", g, 16'h000A);
        chk("cold_refill_addr", last_rd_addr, 16'h0010);
        chk("cold_hit_cnt", hit_cnt, 16'd1);
        chk("cold_miss_cnt", miss_cnt, 16'd1);

        // Write hit, then read it back
        wb_mark = wb_cnt;
        rd_mark = rd_cnt;
        access(16'h0011, 1'b0, 1'b1, 16'hBEEF, ns, g);
        chk("wrhit_stall", 64'(ns), 64'd0);
        access(16'h0011, 1'b1, 1'b0, 16'h0000, ns, g);
        chk("wrhit_rdata", g, 16'hBEEF);
        chk("wrhit_no_traffic", 64'(wb_cnt - wb_mark + rd_cnt - rd_mark), 64'd0);
        chk("wrhit_hit_cnt", hit_cnt, 16'd3);

        // Dirty eviction: same index, different tag
        access(16'h0030, 1'b1, 1'b0, 16'h0000, ns, g);
        chk("evict_wb_addr", last_wb_addr, 16'h0010);
        chk("evict_wb_word1", last_wb_data[31:16], 16'hBEEF);
        chk("evict_refill_addr", last_rd_addr, 16'h0030);
        chk("evict_order", 64'(wb_seq < rd_seq), 64'd1);
        chk("evict_miss_cnt", miss_cnt, 16'd2);

        // Clean eviction back to 0x0010
        wb_mark = wb_cnt;
        access(16'h0010, 1'b1, 1'b0, 16'h0000, ns, g);
        chk("clean_no_wb", 64'(wb_cnt - wb_mark), 64'd0);
        chk("clean_refill_addr", last_rd_addr, 16'h0010);

        // Reset while a refill is outstanding
        mem_lat = 10;
        addr = 16'h0040;
        re = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midalloc_mem_re", mem_re, 1'b1);
        rst = 1'b1;
        re = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_mem_re", mem_re, 1'b0);
        chk("abort_mem_we", mem_we, 1'b0);
        chk("abort_stall", stall, 1'b0);
        chk("abort_hit_cnt", hit_cnt, 16'h0000);
        chk("abort_miss_cnt", miss_cnt, 16'h0000);
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        m_hit = 0;
        m_miss = 0;
        wait_n = 0;
        do begin
            @(posedge clk);
            wait_n++;
        end while (rsp_busy && wait_n < 100);
        #1;
        chk("rsp_drained", 64'(rsp_busy), 64'd0);
        mem_lat = 2;
        access(16'h0040, 1'b1, 1'b0, 16'h0000, ns, g);
        chk("reaccess_miss_cnt", miss_cnt, 16'd1);

        // Random accesses over a few tags so lines collide and get evicted
        for (int n = 0; n < 150; n++) begin
            int tg;
            int op;
            logic [15:0] a;
            tg = $urandom_range(0, 2);
            a  = 16'(tg * 32 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            op = $urandom_range(0, 2);
            mem_lat = $urandom_range(1, 4);
            access(a, op != 1, op != 0, 16'($urandom), ns, g);
        end

        // Hit counter saturation
        mem_lat = 2;
        access(16'h0084, 1'b1, 1'b0, 16'h0000, ns, g);
        addr = 16'h0084;
        re = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        re = 1'b0;
        m_hit = (m_hit + 65540 > 65535) ? 65535 : m_hit + 65540;
        chk("sat_hit_cnt", hit_cnt, 16'hFFFF);
        access(16'h0084, 1'b1, 1'b1, 16'h1357, ns, g);
        chk("rw_both_stall", 64'(ns), 64'd0);
        access(16'h0084, 1'b1, 1'b0, 16'h0000, ns, g);
        chk("rw_both_rdata", g, 16'h1357);
        chk("sat_hit_cnt_held", hit_cnt, 16'hFFFF);

        chk("re_we_exclusive", 64'(both_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
